// File: rtl/prog_loader.sv
// Streams bytes into memory from a programmable base address, optionally reading
// each one back to confirm it landed, while holding the memory port via mem_sel.
module prog_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  verify_en,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  mem_sel,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [DATA_WIDTH-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_RD, S_CMP, S_DONE, S_ERROR
    } state_t;

    // One extra bit so a depth equal to 2^ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH-1:0] err_addr_reg, err_addr_next;
    logic [LEN_WIDTH-1:0]  cnt_reg, cnt_next;
    logic [LEN_WIDTH-1:0]  len_reg, len_next;
    logic                  verify_reg, verify_next;
    logic [DATA_WIDTH-1:0] byte_reg, byte_next;
    logic [DATA_WIDTH-1:0] checksum_reg, checksum_next;
    logic                  addr_oob;
    logic                  accept;

    assign addr_oob = ({1'b0, addr_reg} >= DEPTH_LIM);
    assign busy     = (state_reg == S_WRITE) || (state_reg == S_RD) || (state_reg == S_CMP);
    assign mem_sel  = busy;
    assign s_ready  = (state_reg == S_WRITE) && !addr_oob;
    assign accept   = s_valid && s_ready;
    assign mem_we   = accept;
    assign mem_addr = busy ? addr_reg : '0;
    assign mem_din  = accept ? s_data : '0;
    assign done     = (state_reg == S_DONE);
    assign error    = (state_reg == S_ERROR);
    assign err_addr = err_addr_reg;
    assign checksum = checksum_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            err_addr_reg <= '0;
            cnt_reg      <= '0;
            len_reg      <= '0;
            verify_reg   <= 1'b0;
            byte_reg     <= '0;
            checksum_reg <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            err_addr_reg <= err_addr_next;
            cnt_reg      <= cnt_next;
            len_reg      <= len_next;
            verify_reg   <= verify_next;
            byte_reg     <= byte_next;
            checksum_reg <= checksum_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        err_addr_next = err_addr_reg;
        cnt_next      = cnt_reg;
        len_next      = len_reg;
        verify_next   = verify_reg;
        byte_next     = byte_reg;
        checksum_next = checksum_reg;

        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    len_next      = length;
                    verify_next   = verify_en;
                    addr_next     = base_addr;
                    cnt_next      = '0;
                    err_addr_next = '0;
                    checksum_next = '0;
                    state_next    = (length == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                // Range is checked before the byte is taken, so an out-of-range
                // address never produces a write strobe.
                if (addr_oob) begin
                    err_addr_next = addr_reg;
                    state_next    = S_ERROR;
                end else if (s_valid) begin
                    byte_next     = s_data;
                    checksum_next = checksum_reg + s_data;
                    cnt_next      = cnt_reg + LEN_WIDTH'(1);
                    if (verify_reg) begin
                        state_next = S_RD;
                    end else begin
                        addr_next = addr_reg + ADDR_WIDTH'(1);
                        if (cnt_next == len_reg)
                            state_next = S_DONE;
                    end
                end
            end
            S_RD: begin
                state_next = S_CMP;
            end
            S_CMP: begin
                if (mem_dout != byte_reg) begin
                    err_addr_next = addr_reg;
                    state_next    = S_ERROR;
                end else begin
                    addr_next  = addr_reg + ADDR_WIDTH'(1);
                    state_next = (cnt_reg == len_reg) ? S_DONE : S_WRITE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream of `mem`. Takes a byte stream with a valid/ready handshake and writes it into memory at a programmable base address.
- Optionally reads each byte back and compares it with what was written.
- Owns the memory port while loading (`mem_sel` high), so the core can be held idle while the program image is filled, and then released to the fetcher.
- Replaces bench-driven manual memory loading with synthesizable logic.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 8, memory word and stream byte width.
- MEM_DEPTH, 32, number of valid memory locations; addresses >= MEM_DEPTH are out of range.
- LEN_WIDTH, 16, width of the length field.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load. Sampled only in IDLE, DONE or ERROR.
- base_addr  in  ADDR_WIDTH  first address written; sampled on start.
- length  in  LEN_WIDTH  number of bytes to load; sampled on start.
- verify_en  in  1  enables per-byte readback compare; sampled on start.
- s_valid  in  1  stream byte available.
- s_data  in  DATA_WIDTH  stream byte.
- s_ready  out  1  loader accepts s_data this cycle.
- mem_sel  out  1  high: loader owns the memory port; drives the external address/data/we mux.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_din  out  DATA_WIDTH  write data to memory.
- mem_dout  in  DATA_WIDTH  read data from memory; valid one clk after the address is presented with mem_we=0.
- busy  out  1  load in progress.
- done  out  1  sticky; load completed without error.
- error  out  1  sticky; verify mismatch or out-of-range address.
- err_addr  out  ADDR_WIDTH  address of the first failure.
- checksum  out  DATA_WIDTH  sum of all accepted bytes, mod 2^DATA_WIDTH.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- A reset mid-load aborts at that edge: mem_we=0 and mem_sel=0 from the next cycle, and no partial write occurs after the reset edge.
- States: IDLE, WRITE, RD, CMP, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - Latch base_addr, length and verify_en.
  - Clear done, error, err_addr and checksum.
  - Set cnt=0 and addr=base_addr.
  - If length==0, go to DONE; otherwise go to WRITE.
- busy = (state is WRITE, RD or CMP). mem_sel = busy.
- WRITE:
  - s_ready=1 only in this state.
  - If addr >= MEM_DEPTH, go to ERROR with err_addr=addr and no write. The check happens before accepting the byte, with s_ready=0 that cycle.
  - On s_valid&&s_ready:
    - mem_we=1, mem_addr=addr, mem_din=s_data.
    - Hold the byte, checksum += s_data, cnt++.
    - If verify_en, go to RD.
    - Otherwise addr++; if cnt+1==length go to DONE, else stay in WRITE.
  - s_valid=0 stalls in WRITE with mem_we=0. There is no timeout.
- RD: mem_we=0, mem_addr=held addr; go to CMP.
- CMP: compare mem_dout with the held byte.
  - Mismatch: go to ERROR, err_addr=addr.
  - Match: addr++; go to DONE if cnt==length, else back to WRITE.
- Throughput: 1 byte/cycle with verify off; 3 cycles/byte with verify on.
- addr arithmetic is ADDR_WIDTH wide. Wrap past 2^ADDR_WIDTH-1 is allowed, but any resulting address >= MEM_DEPTH triggers ERROR.
- DONE: done=1. ERROR: error=1. Both hold until the next start or reset; mem_sel=0 in both.
- start while busy is ignored.
- checksum is held after completion.

Test Plan:
- Load without verify:
  - Stimulus: base=0x10, length=4, verify_en=0, stream A9 04 85 02 with s_valid held high.
  - Response: 4 consecutive writes to addresses 0x10..0x13; done asserted on the 5th cycle after start; checksum=0x34; mem_sel low after completion.
- Load with verify:
  - Stimulus: same stream with verify_en=1.
  - Response: 12 busy cycles; memory readback matches; done=1, error=0.
- Stall:
  - Stimulus: s_valid toggled 1,0,0,1 over a 2-byte load.
  - Response: no mem_we during stall cycles; both bytes land at base and base+1.
- Range and zero length:
  - Stimulus: base=0x1E, length=4, MEM_DEPTH=32.
  - Response: writes to 0x1E and 0x1F, then error=1 with err_addr=0x20 and no third write.
  - Stimulus: length=0.
  - Response: done the cycle after start, no writes.
- Verify mismatch:
  - Stimulus: bench corrupts mem_dout to 0xFF on byte 2 with verify_en=1.
  - Response: error=1, err_addr=base+1, done=0.
- Reset and start handling:
  - Stimulus: reset asserted during the 3rd byte of an 8-byte load.
  - Response: next cycle busy=0, mem_we=0, mem_sel=0, checksum=0; a subsequent start loads normally.
  - Stimulus: start pulsed while busy.
  - Response: ignored, with no change to the latched base or length.
